// File: rtl/det_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : det_arbiter_pkg
// Purpose  : Shared types, pattern constant and width helpers for det_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package det_arbiter_pkg;

    localparam logic [6:0] PATTERN = 7'b0101010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } ctrl_state_t;

    // Named by the longest pattern prefix matched so far.
    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_0      = 3'd1,
        DS_01     = 3'd2,
        DS_010    = 3'd3,
        DS_0101   = 3'd4,
        DS_01010  = 3'd5,
        DS_010101 = 3'd6
    } det_state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/det_arbiter_det.sv
`default_nettype none
// ============================================================================
// Module   : pattern_det
// Purpose  : Overlapping Mealy recogniser for 0101010 with a registered flag.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_det
    import det_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    input  logic en,
    output logic flag
);

    det_state_t r_state;
    det_state_t w_next;
    logic       r_flag;
    logic       w_hit;
    logic       w_exp;

    // A mismatch can only fall back to "" or "0" because the pattern alternates.
    always_comb begin
        w_exp  = PATTERN[3'd6 - r_state];
        w_next = r_state;
        w_hit  = 1'b0;
        if (r_state > DS_010101) begin
            w_next = DS_IDLE;
        end else if (din == w_exp) begin
            if (r_state == DS_010101) begin
                w_next = DS_01010;
                w_hit  = 1'b1;
            end else begin
                w_next = det_state_t'(r_state + 3'd1);
            end
        end else begin
            w_next = din ? DS_IDLE : DS_0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DS_IDLE;
            r_flag  <= 1'b0;
        end else if (clr) begin
            r_state <= DS_IDLE;
            r_flag  <= 1'b0;
        end else if (en) begin
            r_state <= w_next;
            r_flag  <= w_hit;
        end else begin
            r_flag  <= 1'b0;
        end
    end

    assign flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/det_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : det_arbiter
// Purpose  : Round-robin sharing of one serial pattern detector among requesters.
// Revision : 1.0 - initial release
// ============================================================================
module det_arbiter
    import det_arbiter_pkg::*;
#(
    parameter  int N_REQ = 2,
    parameter  int WIDTH = 8,
    localparam int ID_W  = idx_width(N_REQ),
    localparam int HIT_W = cnt_width(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [HIT_W-1:0]       res_hits
);

    localparam int BIT_W = idx_width(WIDTH);

    ctrl_state_t      r_state;
    logic [WIDTH-1:0] r_sr;
    logic [BIT_W-1:0] r_bit;
    logic [HIT_W-1:0] r_hits;
    logic [HIT_W-1:0] w_hits_inc;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_win;
    logic             w_found;
    logic             w_start;
    logic             w_flag;
    logic [WIDTH-1:0] w_word;
    logic             r_res_valid;
    logic [ID_W-1:0]  r_res_id;
    logic [HIT_W-1:0] r_res_hits;

    // Two passes give the rotating search: indices above the pointer first, then the rest.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (ID_W'(i) > r_ptr)) begin
                w_found = 1'b1;
                w_win   = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (ID_W'(i) <= r_ptr)) begin
                w_found = 1'b1;
                w_win   = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_word = data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_start    = (r_state == ST_IDLE) && w_found;
    assign w_hits_inc = (w_flag && (r_hits != HIT_W'(WIDTH))) ? r_hits + 1'b1 : r_hits;

    always_comb begin
        gnt = '0;
        if (w_start && rst) begin
            gnt[w_win] = 1'b1;
        end
    end

    pattern_det u_det (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start),
        .din  (r_sr[WIDTH-1]),
        .en   (r_state == ST_SHIFT),
        .flag (w_flag)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_bit       <= '0;
            r_hits      <= '0;
            r_ptr       <= ID_W'(N_REQ - 1);
            r_id        <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_hits  <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sr    <= w_word;
                        r_id    <= w_win;
                        r_ptr   <= w_win;
                        r_hits  <= '0;
                        r_bit   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sr   <= {r_sr[WIDTH-2:0], 1'b0};
                    r_hits <= w_hits_inc;
                    if (r_bit == BIT_W'(WIDTH - 1)) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The flag of the final bit arrives now, so fold it straight into the result.
                    r_hits      <= w_hits_inc;
                    r_res_hits  <= w_hits_inc;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_REPORT;
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_hits  = r_res_hits;

endmodule
`default_nettype wire

// File: tb/tb_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_det_arbiter
// Purpose  : Self-checking bench for det_arbiter (8-bit and 12-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_det_arbiter;
    import det_arbiter_pkg::*;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_a = '0, req_b = '0;
    logic [15:0] data_a = '0;
    logic [23:0] data_b = '0;
    logic [1:0]  gnt_a, gnt_b;
    logic        busy_a, busy_b, rv_a, rv_b;
    logic [0:0]  id_a, id_b;
    logic [3:0]  hits_a, hits_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int m_cnt  [2] = '{0, 0};
    int m_ptr  [2] = '{N-1, N-1};
    int m_id   [2] = '{0, 0};
    int m_hits [2] = '{0, 0};
    int m_pid  [2] = '{0, 0};
    int m_phits[2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    det_arbiter #(.N_REQ(2), .WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .data(data_a), .gnt(gnt_a),
        .busy(busy_a), .res_valid(rv_a), .res_id(id_a), .res_hits(hits_a)
    );

    det_arbiter #(.N_REQ(2), .WIDTH(12)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .data(data_b), .gnt(gnt_b),
        .busy(busy_b), .res_valid(rv_b), .res_id(id_b), .res_hits(hits_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hits are every 7-bit window of the word (first bit first) equal to the pattern.
    function automatic int ref_hits(input logic [31:0] word, input int w);
        logic [6:0] win;
        int hits;
        win  = '0;
        hits = 0;
        for (int i = w - 1; i >= 0; i--) begin
            win = {win[5:0], word[i]};
            if ((w - 1 - i) >= 6 && win == PATTERN) hits++;
        end
        return hits;
    endfunction

    // Model: a busy countdown of WIDTH+2 cycles after each grant; result shows in its last cycle.
    task automatic model_cycle(input int d, input int w, input logic [1:0] r, input logic [31:0] dat,
                               input logic [1:0] g, input logic b, input logic v,
                               input logic [0:0] id, input logic [3:0] h);
        int win;
        logic [31:0] word;
        if (!rst) begin
            m_cnt[d] = 0; m_ptr[d] = N - 1; m_id[d] = 0; m_hits[d] = 0;
        end
        win = -1;
        for (int k = 1; k <= N; k++) begin
            if (win < 0 && r[(m_ptr[d] + k) % N]) win = (m_ptr[d] + k) % N;
        end
        check($sformatf("gnt%0d", d), {30'b0, g},
              (rst && m_cnt[d] == 0 && win >= 0) ? (32'd1 << win) : 32'd0);
        check($sformatf("busy%0d", d), {31'b0, b}, (m_cnt[d] != 0) ? 32'd1 : 32'd0);
        check($sformatf("res_valid%0d", d), {31'b0, v}, (m_cnt[d] == 1) ? 32'd1 : 32'd0);
        check($sformatf("res_id%0d", d), {31'b0, id}, m_id[d]);
        check($sformatf("res_hits%0d", d), {28'b0, h}, m_hits[d]);
        if (rst) begin
            if (m_cnt[d] == 0 && win >= 0) begin
                word       = (dat >> (win * w)) & ((32'd1 << w) - 32'd1);
                m_ptr[d]   = win;
                m_pid[d]   = win;
                m_phits[d] = ref_hits(word, w);
                m_cnt[d]   = w + 2;
            end else if (m_cnt[d] > 0) begin
                m_cnt[d]--;
                if (m_cnt[d] == 1) begin
                    m_id[d]   = m_pid[d];
                    m_hits[d] = m_phits[d];
                end
            end
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0, 8,  req_a, {16'b0, data_a}, gnt_a, busy_a, rv_a, id_a, hits_a);
        model_cycle(1, 12, req_b, {8'b0,  data_b}, gnt_b, busy_b, rv_b, id_b, hits_b);
    end

    task automatic run_word_a(input int idx, input logic [7:0] w, input int exp_hits, input string tag);
        int  t;
        bit  ok;
        @(posedge clk); #1;
        req_a[idx] = 1'b1;
        data_a[idx*8 +: 8] = w;
        ok = 0; t = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (gnt_a[idx]) begin ok = 1; t = cyc; end
        end
        check({tag, "_gnt"}, ok, 1);
        @(posedge clk); #1;
        req_a = '0;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rv_a) ok = 1;
        end
        check({tag, "_valid"}, ok, 1);
        check({tag, "_latency"}, cyc - t, 10);
        check({tag, "_id"}, {31'b0, id_a}, idx);
        check({tag, "_hits"}, {28'b0, hits_a}, exp_hits);
    endtask

    initial begin
        int  t, n;
        bit  ok;
        int  gi[4];
        int  gt[4];

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt",   {30'b0, gnt_a}, 0);
        check("rst_busy",  {31'b0, busy_a}, 0);
        check("rst_valid", {31'b0, rv_a}, 0);
        check("rst_id",    {31'b0, id_a}, 0);
        check("rst_hits",  {28'b0, hits_a}, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", {31'b0, busy_a}, 0);

        run_word_a(0, 8'b0101_0100, 1, "single");
        run_word_a(1, 8'hFF, 0, "nomatch");

        // Overlapping matches in the 12-bit instance.
        @(posedge clk); #1;
        req_b = 2'b01;
        data_b[11:0] = 12'b0101_0101_0100;
        ok = 0; t = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (gnt_b[0]) begin ok = 1; t = cyc; end
        end
        check("overlap_gnt", ok, 1);
        @(posedge clk); #1 req_b = '0;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rv_b) ok = 1;
        end
        check("overlap_valid", ok, 1);
        check("overlap_latency", cyc - t, 14);
        check("overlap_hits", {28'b0, hits_b}, 3);

        // Both requesters held: grants must alternate, 11 cycles apart.
        @(posedge clk); #1;
        data_a = {8'hAA, 8'h54};
        req_a  = 2'b11;
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk);
            if (gnt_a != 2'b00) begin
                gi[n] = gnt_a[1] ? 1 : 0;
                gt[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1 req_a = '0;
        check("rr_count", n, 4);
        for (int i = 0; i < n; i++) check($sformatf("rr_idx%0d", i), gi[i], i % 2);
        for (int i = 1; i < n; i++) check($sformatf("rr_gap%0d", i), gt[i] - gt[i-1], 11);
        repeat (14) @(posedge clk);

        // Reset during SHIFT bit 4 aborts the word.
        #1;
        req_a = 2'b01;
        data_a = {8'h00, 8'h54};
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (gnt_a[0]) ok = 1;
        end
        check("midrst_gnt", ok, 1);
        @(posedge clk); #1 req_a = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_gnt0",  {30'b0, gnt_a}, 0);
        check("midrst_busy",  {31'b0, busy_a}, 0);
        check("midrst_valid", {31'b0, rv_a}, 0);
        check("midrst_id",    {31'b0, id_a}, 0);
        check("midrst_hits",  {28'b0, hits_a}, 0);
        repeat (2) @(posedge clk);
        #1;
        req_a = 2'b11;
        rst   = 1'b1;
        @(negedge clk);
        check("post_rst_first", {30'b0, gnt_a}, 1);
        @(posedge clk); #1 req_a = '0;
        repeat (14) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/det_arbiter.md
# det_arbiter

Round-robin controller that shares one serial pattern detector between `N_REQ` parallel-word requesters. Accepts one `WIDTH`-bit word at a time, shifts it MSB-first through the detector at one bit per clock, and counts detector hits inside that word. Reports the hit count tagged with the requester index. Sits between byte-wide producers and the bit-serial detection path.

## Interface
Parameters:
- `N_REQ`, default 2. Number of requesters; must be ≥ 2.
- `WIDTH`, default 8. Word width in bits; must be ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request; held until granted.
- `data`  in  N_REQ*WIDTH  requester i's word is `data[i*WIDTH +: WIDTH]`; valid while `req[i]` is high.
- `gnt`  out  N_REQ  one-hot; one-cycle pulse. `data` of the granted requester is captured on that edge.
- `busy`  out  1  high in every state except IDLE.
- `res_valid`  out  1  one-cycle pulse: the result is ready.
- `res_id`  out  clog2(N_REQ)  index of the requester whose word produced the result.
- `res_hits`  out  clog2(WIDTH+1)  hit count for that word. Holds its value until the next `res_valid`.

## Operation
- Detector sub-module:
  - Mealy recogniser for the bit sequence 0101010, first bit first. Overlapping matches are allowed: after a match, a further "10" produces another hit.
  - Output `flag` is registered. It is high in the cycle after the bit that completes the pattern.
  - Synchronous `clr` returns it to the idle state, in which a leading 1 is ignored. The detector has no unknown or X state.
- Controller state machine, states IDLE, SHIFT, DRAIN, REPORT:
  - **IDLE:** if any `req` bit is high, pick a winner, assert `gnt[winner]` combinationally, and on that edge:
    - capture the winner's word into the shift register;
    - latch the winner's index;
    - pulse `clr` to the detector;
    - clear the hit counter;
    - go to SHIFT.
  - **SHIFT:** drive the detector with the shift register MSB and shift left; bit counter runs 0..WIDTH-1. After bit WIDTH-1, go to DRAIN.
  - **DRAIN:** one cycle, with no detector input valid. This captures the flag produced by the last bit. Then go to REPORT.
  - **REPORT:** assert `res_valid`; `res_id` and `res_hits` are updated on entry. Then go to IDLE.
- Hit counting: add 1 to the hit counter on each cycle in SHIFT or DRAIN in which `flag` is high. The counter saturates at WIDTH and never wraps.
- Arbitration: round-robin.
  - A pointer holds the last granted index. Search starts at pointer+1 and wraps modulo N_REQ.
  - After reset the pointer equals N_REQ-1, so requester 0 has first priority.
  - A single active requester is granted back-to-back.
- No preemption: changes on `req`/`data` outside the grant cycle are ignored.

## Timing
- Reset values: `gnt`=0, `busy`=0, `res_valid`=0, `res_id`=0, `res_hits`=0. State returns to IDLE, detector to idle, pointer to N_REQ-1.
- Reset asserted mid-word aborts the word. No `res_valid` is produced for it.
- Latency, with grant at edge t:
  - SHIFT covers cycles t+1..t+WIDTH;
  - DRAIN is cycle t+WIDTH+1;
  - `res_valid` is high in cycle t+WIDTH+2.
- Earliest next grant is cycle t+WIDTH+3. Throughput is one word per WIDTH+3 cycles.
- `gnt` is asserted only in IDLE, is at most one-hot, and is never asserted while `busy`.
- Detector context does not carry across words: a pattern split between two words is not detected.

## Structure
- Shared package:
  - state encoding enum (IDLE, SHIFT, DRAIN, REPORT);
  - detector state enum;
  - `PATTERN` constant (7'b0101010);
  - width helper functions for the clog2 sizes.
- Sub-module `pattern_det`: ports `clk`, `rst`, `clr`, `din`, `en`, `flag`. The top level contains the arbiter, shift register, counters and controller FSM.

## Test plan
- Reset values: with reset held, check every output is 0. Release reset; with no requests, check `busy` stays 0.
- Single match: `req[0]`=1 with `data[0]`=8'b0101_0100 → `gnt[0]` pulse, then `res_valid` 10 cycles after the grant with `res_id`=0 and `res_hits`=1.
- No match: `data[1]`=8'hFF → `res_hits`=0.
- Overlap, with `WIDTH`=12: word 12'b0101_0101_0100 → `res_hits`=3.
- Round-robin: both `req` held high continuously → grants alternate 0,1,0,1. Consecutive grants are exactly 11 cycles apart, and each `res_id` matches its grant.
- Mid-word reset: assert `rst`=0 at SHIFT bit 4 → all outputs go to 0 immediately with no `res_valid`. After release, requester 0 wins first.
